// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: processes one bit per clock, LSB first, and
// presents a registered result with carry and signed overflow when it finishes.
module serial_add_sub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             load_c;
   logic             shift_c;
   logic             last_c;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic             carry_msb;
   logic [CW-1:0]    cnt;

   logic             bit_s_c;
   logic             bit_c_c;

   // One full-adder slice on the current LSBs.
   assign bit_s_c = op_a[0] ^ op_b[0] ^ carry;
   assign bit_c_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

   // Next-state and datapath strobes.
   always_comb begin
      state_next = state;
      load_c     = 1'b0;
      shift_c    = 1'b0;
      last_c     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_c     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shift_c = 1'b1;
            if (cnt == CNT_LAST) begin
               last_c     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load_c     = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register with status flags decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         ready <= (state_next != SHIFT);
         busy  <= (state_next == SHIFT);
         done  <= (state_next == DONE);
      end
   end

   // Operand shifters, carry chain and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a      <= '0;
         op_b      <= '0;
         res       <= '0;
         carry     <= 1'b0;
         carry_msb <= 1'b0;
         cnt       <= '0;
      end else if (load_c) begin
         op_a      <= a;
         op_b      <= sub ? ~b : b;
         carry     <= sub ? 1'b1 : cin;
         res       <= '0;
         carry_msb <= 1'b0;
         cnt       <= '0;
      end else if (shift_c) begin
         op_a  <= {1'b0, op_a[WIDTH-1:1]};
         op_b  <= {1'b0, op_b[WIDTH-1:1]};
         res   <= {bit_s_c, res[WIDTH-1:1]};
         carry <= bit_c_c;
         cnt   <= cnt + CW'(1);
         // Carry leaving bit WIDTH-2 is the carry into the sign bit.
         if (cnt == CNT_PREV) begin
            carry_msb <= bit_c_c;
         end
      end
   end

   // Result registers only move on the final bit, so they hold during SHIFT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (last_c) begin
         sum      <= {bit_s_c, res[WIDTH-1:1]};
         cout     <= bit_c_c;
         overflow <= carry_msb ^ bit_c_c;
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub (WIDTH=8): directed vectors push expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_serial_add_sub;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   serial_add_sub #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout),
      .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sum", int'(sum), int'(e.sum));
            chk("cout", int'(cout), int'(e.cout));
            chk("overflow", int'(overflow), int'(e.ovf));
            chk("done_latency", cyc, e.cyc);
         end
      end
   end

   // Drive start for one edge; optionally record the expected result.
   task automatic issue(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic c, input logic push, input logic [W-1:0] es,
                        input logic ec, input logic eo);
      exp_t e;
      @(negedge clk);
      start = 1'b1; sub = s; a = av; b = bv; cin = c;
      @(posedge clk);
      #1;
      if (push) begin
         e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + int'(W);
         exp_q.push_back(e);
      end
      start = 1'b0;
   endtask

   // Wait for done (bounded), counting busy cycles and checking result hold.
   // inject: pulse a stray start on the 3rd SHIFT cycle.
   task automatic wait_done(input logic inject, input logic [W-1:0] hold_sum,
                            output int busy_cnt);
      logic seen;
      seen = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (inject && i == 3) start = 1'b0;
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) busy_cnt++;
            if (sum != hold_sum) chk("sum_hold", int'(sum), int'(hold_sum));
            if (inject && i == 2) begin
               start = 1'b1; sub = 1'b1; a = 8'hFF; b = 8'h77; cin = 1'b1;
            end
         end
      end
      chk("done_seen", int'(seen), 1);
   endtask

   initial begin
      int bc;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      #12;
      chk("rst_ready", int'(ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sum", int'(sum), 0);
      chk("rst_cout", int'(cout), 0);
      chk("rst_ovf", int'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;

      // Basic add with latency and pulse width checks.
      issue(1'b0, 8'h05, 8'h03, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
      chk("shift_ready", int'(ready), 0);
      chk("shift_busy", int'(busy), 1);
      wait_done(1'b0, 8'h00, bc);
      chk("busy_cycles", bc, 8);
      @(negedge clk);
      chk("done_pulse", int'(done), 0);
      chk("idle_ready", int'(ready), 1);

      issue(1'b0, 8'hFF, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
      wait_done(1'b0, 8'h08, bc);
      issue(1'b0, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
      wait_done(1'b0, 8'h01, bc);
      issue(1'b1, 8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      wait_done(1'b0, 8'h80, bc);
      issue(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      wait_done(1'b0, 8'hFE, bc);

      // Stray start during SHIFT must be ignored.
      issue(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
      wait_done(1'b1, 8'h7F, bc);
      chk("busy_continuous", bc, 8);
      start = 1'b0;

      // Asynchronous reset mid-operation aborts it with no done pulse.
      issue(1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_ready", int'(ready), 1);
      chk("arst_busy", int'(busy), 0);
      chk("arst_sum", int'(sum), 0);
      chk("arst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("arst_no_done", int'(done), 0);
      issue(1'b0, 8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
      wait_done(1'b0, 8'h00, bc);

      // Back-to-back: start held on the done cycle restarts with no IDLE gap.
      start = 1'b1; sub = 1'b0; a = 8'hAA; b = 8'h55; cin = 1'b0;
      @(posedge clk);
      #1;
      begin
         exp_t e;
         e.sum = 8'hFF; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = cyc + int'(W);
         exp_q.push_back(e);
      end
      start = 1'b0;
      chk("b2b_busy", int'(busy), 1);
      chk("b2b_hold", int'(sum), 8'h02);
      wait_done(1'b0, 8'h02, bc);
      chk("b2b_busy_cycles", bc, 8);

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
